// File: rtl/vector_player_pkg.sv
// rtl/vector_player_pkg.sv - shared types, state codes, default widths and field offsets for vector_player
// Contents:
//   DEF_*       default parameter values for vector_player
//   EXP_LSB     bit offset of the expected-response field inside a ROM word
//   stim_lsb()  bit offset of the stimulus field (sits directly above exp)
//   vp_state_t  FSM state type with ST_* encodings
package vector_player_pkg;

  localparam int DEF_STIM_W     = 3;
  localparam int DEF_RESP_W     = 1;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_MAX_VEC    = 32;
  localparam int DEF_SETTLE_CYC = 1;
  localparam int DEF_CNT_W      = 16;

  // ROM word layout is {stim, exp}: exp in the LSBs, stim right above it.
  localparam int EXP_LSB = 0;

  function automatic int stim_lsb(input int resp_w);
    return EXP_LSB + resp_w;
  endfunction

  typedef logic [2:0] vp_state_t;

  localparam vp_state_t ST_IDLE   = 3'd0;
  localparam vp_state_t ST_FETCH  = 3'd1;
  localparam vp_state_t ST_APPLY  = 3'd2;
  localparam vp_state_t ST_SETTLE = 3'd3;
  localparam vp_state_t ST_CHECK  = 3'd4;
  localparam vp_state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/vector_player_sat_counter.sv
// rtl/vector_player_sat_counter.sv - clearable up-counter that sticks at all-ones
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset, clears q
//   clr    synchronous clear (wins over inc)
//   inc    increment request; ignored once q is all-ones
//   q      current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/vector_player.sv
// rtl/vector_player.sv - ROM-driven stimulus/response sequencer for on-chip bring-up of datapath blocks
// Optional feature macro: VECTOR_PLAYER_FAIL_CAPTURE_EN (first-mismatch capture outputs)
// Ports:
//   clk_in     clock, rising edge
//   rst_in     asynchronous active-low reset
//   start      one-cycle pulse starting a pass (ignored while busy)
//   vec_addr   ROM read address
//   vec_data   ROM word {stim, exp}, one cycle after vec_addr
//   vec_valid  ROM entry present; 0 terminates the table
//   stim       registered stimulus to the device under test
//   dut_resp   response of the device under test
//   busy       pass in progress
//   done       pass finished, held until next start
//   pass       done with zero mismatches
//   vec_count  vectors checked this pass (saturating)
//   err_count  mismatches this pass (saturating)
//   fail_*     first-mismatch capture (macro builds only)
module vector_player
  import vector_player_pkg::*;
#(
  parameter int STIM_W     = DEF_STIM_W,
  parameter int RESP_W     = DEF_RESP_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MAX_VEC    = DEF_MAX_VEC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start,
  output logic [ADDR_W-1:0]        vec_addr,
  input  logic [STIM_W+RESP_W-1:0] vec_data,
  input  logic                     vec_valid,
  output logic [STIM_W-1:0]        stim,
  input  logic [RESP_W-1:0]        dut_resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         vec_count,
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
  output logic [CNT_W-1:0]         err_count,
  output logic                     fail_valid,
  output logic [ADDR_W-1:0]        fail_idx,
  output logic [STIM_W-1:0]        fail_stim,
  output logic [RESP_W-1:0]        fail_resp,
  output logic [RESP_W-1:0]        fail_exp
`else
  output logic [CNT_W-1:0]         err_count
`endif
);

  localparam int STIM_LSB = stim_lsb(RESP_W);
  // Settle counter only needs to hold SETTLE_CYC-1; keep at least one bit.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_VEC - 1);

  vp_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [STIM_W-1:0]  stim_q, stim_d;
  logic [RESP_W-1:0]  exp_q, exp_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               clr_cnt;
  logic               inc_vec;
  logic               inc_err;
  logic               mismatch;

  assign mismatch = (dut_resp != exp_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stim_d   = stim_q;
    exp_d    = exp_q;
    settle_d = settle_q;
    clr_cnt  = 1'b0;
    inc_vec  = 1'b0;
    inc_err  = 1'b0;
    case (state_q)
      // DONE shares the IDLE start path so a new pass can follow directly.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr_cnt = 1'b1;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (!vec_valid) begin
          state_d = ST_DONE;
        end else begin
          stim_d   = vec_data[STIM_LSB +: STIM_W];
          exp_d    = vec_data[EXP_LSB +: RESP_W];
          settle_d = SET_W'(SETTLE_CYC - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_CHECK: begin
        inc_vec = 1'b1;
        inc_err = mismatch;
        // The last slot ends the pass without advancing idx, so it never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      stim_q   <= '0;
      exp_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stim_q   <= stim_d;
      exp_q    <= exp_d;
      settle_q <= settle_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk_in),
    .rst_n (rst_in),
    .clr   (clr_cnt),
    .inc   (inc_vec),
    .q     (vec_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk_in),
    .rst_n (rst_in),
    .clr   (clr_cnt),
    .inc   (inc_err),
    .q     (err_count)
  );

  assign vec_addr = idx_q;
  assign stim     = stim_q;
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_APPLY) ||
                    (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (err_count == '0);

`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
  logic              fail_valid_q;
  logic [ADDR_W-1:0] fail_idx_q;
  logic [STIM_W-1:0] fail_stim_q;
  logic [RESP_W-1:0] fail_resp_q;
  logic [RESP_W-1:0] fail_exp_q;

  // Only the first mismatch of a pass is kept; fail_valid_q blocks overwrites.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      fail_stim_q  <= '0;
      fail_resp_q  <= '0;
      fail_exp_q   <= '0;
    end else if (clr_cnt) begin
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      fail_stim_q  <= '0;
      fail_resp_q  <= '0;
      fail_exp_q   <= '0;
    end else if ((state_q == ST_CHECK) && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_idx_q   <= idx_q;
      fail_stim_q  <= stim_q;
      fail_resp_q  <= dut_resp;
      fail_exp_q   <= exp_q;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign fail_stim  = fail_stim_q;
  assign fail_resp  = fail_resp_q;
  assign fail_exp   = fail_exp_q;
`endif

endmodule

// File: tb/tb_vector_player.sv
// tb/tb_vector_player.sv - scoreboard testbench for vector_player (three parameterisations, loopback DUT)
module tb_vector_player;

  localparam int SW = 3;
  localparam int RW = 1;
  localparam int AW = 5;
  localparam int DW = SW + RW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance a: defaults. Instance b: CNT_W=2. Instance c: MAX_VEC=4.
  logic          start_a, start_b, start_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [DW-1:0] data_a, data_b, data_c;
  logic          valid_a, valid_b, valid_c;
  logic [SW-1:0] stim_a, stim_b, stim_c;
  logic [RW-1:0] resp_a, resp_b, resp_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;
  logic          pass_a, pass_b, pass_c;
  logic [15:0]   vcnt_a, ecnt_a, vcnt_c, ecnt_c;
  logic [1:0]    vcnt_b, ecnt_b;
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
  logic          fv_a, fv_b, fv_c;
  logic [AW-1:0] fidx_a, fidx_b, fidx_c;
  logic [SW-1:0] fstim_a, fstim_b, fstim_c;
  logic [RW-1:0] fresp_a, fresp_b, fresp_c;
  logic [RW-1:0] fexp_a, fexp_b, fexp_c;
`endif

  logic [DW-1:0] rom_a [32];
  logic [DW-1:0] rom_b [32];
  logic [DW-1:0] rom_c [32];
  logic [31:0]   rv_a, rv_b, rv_c;

  // Synchronous ROMs (1-cycle latency) and registered loopback DUTs.
  always_ff @(posedge clk) begin
    data_a  <= rom_a[addr_a];
    valid_a <= rv_a[addr_a];
    data_b  <= rom_b[addr_b];
    valid_b <= rv_b[addr_b];
    data_c  <= rom_c[addr_c];
    valid_c <= rv_c[addr_c];
    resp_a  <= stim_a[0];
    resp_b  <= stim_b[0];
    resp_c  <= stim_c[0];
  end

  vector_player dut_a (
    .clk_in(clk), .rst_in(rst_n), .start(start_a), .vec_addr(addr_a), .vec_data(data_a),
    .vec_valid(valid_a), .stim(stim_a), .dut_resp(resp_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .vec_count(vcnt_a),
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
    .fail_valid(fv_a), .fail_idx(fidx_a), .fail_stim(fstim_a), .fail_resp(fresp_a), .fail_exp(fexp_a),
`endif
    .err_count(ecnt_a)
  );

  vector_player #(.CNT_W(2)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .start(start_b), .vec_addr(addr_b), .vec_data(data_b),
    .vec_valid(valid_b), .stim(stim_b), .dut_resp(resp_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .vec_count(vcnt_b),
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
    .fail_valid(fv_b), .fail_idx(fidx_b), .fail_stim(fstim_b), .fail_resp(fresp_b), .fail_exp(fexp_b),
`endif
    .err_count(ecnt_b)
  );

  vector_player #(.MAX_VEC(4)) dut_c (
    .clk_in(clk), .rst_in(rst_n), .start(start_c), .vec_addr(addr_c), .vec_data(data_c),
    .vec_valid(valid_c), .stim(stim_c), .dut_resp(resp_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .vec_count(vcnt_c),
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
    .fail_valid(fv_c), .fail_idx(fidx_c), .fail_stim(fstim_c), .fail_resp(fresp_c), .fail_exp(fexp_c),
`endif
    .err_count(ecnt_c)
  );

  typedef struct {
    int id;
    int vec;
    int err;
    int pass;
    int fv;
    int fidx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input int id, input int vec, input int err, input int p,
                          input int fv, input int fidx);
    exp_t e;
    e.id = id; e.vec = vec; e.err = err; e.pass = p; e.fv = fv; e.fidx = fidx;
    sb_q.push_back(e);
  endtask

  task automatic score(input int id, input int vec, input int err, input int p,
                       input int fv, input int fidx);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_done: instance %0d finished with no expectation queued", id);
    end else begin
      e = sb_q.pop_front();
      chk("sb_instance", id, e.id);
      chk("vec_count", vec, e.vec);
      chk("err_count", err, e.err);
      chk("pass", p, e.pass);
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
      chk("fail_valid", fv, e.fv);
      if (e.fv != 0) chk("fail_idx", fidx, e.fidx);
`else
      if (fv != fidx) chk("fail_unused", fv, fidx);
`endif
    end
  endtask

  // Monitor: scores each instance on the rising edge of done.
  logic done_prev_a = 1'b0, done_prev_b = 1'b0, done_prev_c = 1'b0;
  int   max_addr_c = 0;
  always @(negedge clk) begin
    if (done_a && !done_prev_a) begin
`ifdef VECTOR_PLAYER_FAIL_CAPTURE_EN
      score(0, int'(vcnt_a), int'(ecnt_a), int'(pass_a), int'(fv_a), int'(fidx_a));
`else
      score(0, int'(vcnt_a), int'(ecnt_a), int'(pass_a), 0, 0);
`endif
    end
    if (done_b && !done_prev_b) score(1, int'(vcnt_b), int'(ecnt_b), int'(pass_b), 0, 0);
    if (done_c && !done_prev_c) score(2, int'(vcnt_c), int'(ecnt_c), int'(pass_c), 0, 0);
    done_prev_a = done_a;
    done_prev_b = done_b;
    done_prev_c = done_c;
    if (int'(addr_c) > max_addr_c) max_addr_c = int'(addr_c);
  end

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic get_done(input int id);
    case (id)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Pulses start; cyc counts rising edges after the edge that sampled start.
  task automatic run_pass(input int id, input int bound, output int cyc);
    @(posedge clk); #1 set_start(id, 1'b1);
    @(posedge clk); #1 set_start(id, 1'b0);
    cyc = 0;
    while (!get_done(id) && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_reached", int'(get_done(id)), 1);
  endtask

  task automatic load_a(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    rom_a[0] = d0; rom_a[1] = d1; rom_a[2] = d2; rom_a[3] = d3;
    rv_a = 32'h0000_000F;
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rv_a = '0; rv_b = '0; rv_c = '0;
    for (int i = 0; i < 32; i++) begin
      rom_a[i] = '0;
      rom_b[i] = '0;
      // Full, correct loopback table: stim=i[2:0], exp=i[0].
      rom_c[i] = {3'(i), 1'(i)};
    end
    rv_c = 32'hFFFF_FFFF;
    // Every entry fails: exp = ~stim[0].
    rom_b[0] = 4'b0010; rom_b[1] = 4'b0101; rom_b[2] = 4'b1110;
    rom_b[3] = 4'b1001; rom_b[4] = 4'b0010;
    rv_b = 32'h0000_001F;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_stim", int'(stim_a), 0);
    chk("rst_vec_count", int'(vcnt_a), 0);

    // 1: four correct loopback vectors then end marker.
    load_a(4'b0011, 4'b0100, 4'b1111, 4'b1000);
    push_exp(0, 4, 0, 1, 0, 0);
    run_pass(0, 40, cyc);
    chk("t1_latency", int'(cyc >= 17 && cyc <= 18), 1);
    chk("t1_stim_held", int'(stim_a), 3'b100);

    // 2: exp inverted at idx 1 and 3.
    load_a(4'b0011, 4'b0101, 4'b1111, 4'b1001);
    push_exp(0, 4, 2, 0, 1, 1);
    run_pass(0, 40, cyc);

    // 3: empty table.
    rv_a = '0;
    push_exp(0, 0, 0, 1, 0, 0);
    run_pass(0, 10, cyc);
    chk("t3_latency", int'(cyc <= 3), 1);

    // 4: reset during SETTLE of vector 2, then a clean rerun.
    load_a(4'b0011, 4'b0100, 4'b1111, 4'b1000);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("t4_busy_after_start", int'(busy_a), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_pre_rst_vec_count", int'(vcnt_a), 2);
    chk("t4_pre_rst_addr", int'(addr_a), 2);
    chk("t4_pre_rst_stim", int'(stim_a), 3'b111);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", int'(busy_a), 0);
    chk("t4_rst_stim", int'(stim_a), 0);
    chk("t4_rst_addr", int'(addr_a), 0);
    chk("t4_rst_vec_count", int'(vcnt_a), 0);
    chk("t4_rst_done", int'(done_a), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    push_exp(0, 4, 0, 1, 0, 0);
    run_pass(0, 40, cyc);

    // 5: CNT_W=2, five failing vectors -> both counters saturate at 3.
    push_exp(1, 3, 3, 0, 0, 0);
    run_pass(1, 60, cyc);

    // 6: MAX_VEC=4, full ROM, start pulsed while busy.
    push_exp(2, 4, 0, 1, 0, 0);
    @(posedge clk); #1 start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    cyc = 0;
    while (!done_c && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start_c = (cyc == 5);
    end
    start_c = 1'b0;
    chk("t6_done", int'(done_c), 1);
    chk("t6_latency", cyc, 16);
    chk("t6_max_addr", max_addr_c, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
